// File: rtl/uart_tx_fifo.sv
`default_nettype none
//==============================================================================
// Module      : uart_tx_fifo
// Description : A transmit FIFO that sits in front of a UART transmitter.
//               Words are stored in a DEPTH-entry circular buffer. A small
//               launch FSM pops one word at a time into the transmitter. It
//               waits for the transmitter to report busy, and then idle
//               again, before it launches the next word.
//
// Ports       : clk          - system clock, all logic on posedge
//               rst_n        - synchronous active-low reset
//               wr_data      - word to enqueue
//               wr_en        - enqueue strobe (one word per high cycle)
//               full         - registered, count == DEPTH
//               empty        - registered, count == 0
//               count        - registered number of stored words, 0..DEPTH
//               tx_data      - word presented to transmitter datain
//               tx_send      - one-cycle start pulse to transmitter send_tx
//               tx_ready     - transmitter idle flag
//               overflow     - sticky dropped-write flag (optional)
//               overflow_clr - clears overflow (optional)
//
// Build macro : UART_TX_FIFO_OVERFLOW_FLAG_EN adds the overflow/overflow_clr
//               ports. When it is not defined, dropped writes are silent.
//
// Revision    : 1.0 - initial release
//==============================================================================

`ifndef UART_CONFIG_WIDTH_DATABITS
`define UART_CONFIG_WIDTH_DATABITS 8
`endif

module uart_tx_fifo #(
    parameter int DATA_WIDTH = `UART_CONFIG_WIDTH_DATABITS,
    parameter int DEPTH      = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic                    wr_en,
    output logic                    full,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  count,
    output logic [DATA_WIDTH-1:0]   tx_data,
    output logic                    tx_send,
    input  logic                    tx_ready
`ifdef UART_TX_FIFO_OVERFLOW_FLAG_EN
    ,
    output logic                    overflow,
    input  logic                    overflow_clr
`endif
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_CW = c_AW + 1;
    localparam logic [c_CW-1:0] c_FULL_COUNT = c_CW'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_LAUNCH    = 2'd1,
        ST_WAIT_BUSY = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [DATA_WIDTH-1:0]  r_mem [DEPTH];
    logic [c_AW-1:0]        r_wptr;
    logic [c_AW-1:0]        r_rptr;
    logic [c_CW-1:0]        r_count;
    logic [c_CW-1:0]        w_count_nxt;
    logic                   r_full;
    logic                   r_empty;
    logic [DATA_WIDTH-1:0]  r_tx_data;
    logic                   w_push;
    logic                   w_pop;

    // The write is qualified by the registered (pre-edge) full flag. A write
    // that arrives in the same cycle as a pop from a full FIFO is therefore
    // still dropped.
    assign w_push = wr_en && !r_full;

    // Launch FSM. The pop happens on the edge that leaves IDLE. tx_send is
    // then simply "in LAUNCH", which makes it exactly one cycle wide.
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!r_empty && tx_ready) begin
                    w_pop       = 1'b1;
                    w_state_nxt = ST_LAUNCH;
                end
            end
            ST_LAUNCH:    w_state_nxt = ST_WAIT_BUSY;
            // The transmitter must be seen busy before it is trusted as idle
            // again. Otherwise a stale ready could start a second launch.
            ST_WAIT_BUSY: if (!tx_ready) w_state_nxt = ST_IDLE;
            default:      w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + c_CW'(1);
            2'b01:   w_count_nxt = r_count - c_CW'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    // Storage has no reset. Entries are only meaningful through the pointers.
    always_ff @(posedge clk) begin
        if (rst_n && w_push) r_mem[r_wptr] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_count   <= '0;
            r_full    <= 1'b0;
            r_empty   <= 1'b1;
            r_tx_data <= '0;
        end else begin
            // DEPTH is a power of two, so pointer overflow is the wrap.
            if (w_push) r_wptr <= r_wptr + c_AW'(1);
            if (w_pop) begin
                r_rptr    <= r_rptr + c_AW'(1);
                r_tx_data <= r_mem[r_rptr];
            end
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == c_FULL_COUNT);
            r_empty <= (w_count_nxt == '0);
        end
    end

    assign full    = r_full;
    assign empty   = r_empty;
    assign count   = r_count;
    assign tx_data = r_tx_data;
    assign tx_send = (r_state == ST_LAUNCH);

`ifdef UART_TX_FIFO_OVERFLOW_FLAG_EN
    logic r_overflow;

    // Setting takes priority over a clear in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst_n)                r_overflow <= 1'b0;
        else if (wr_en && r_full)  r_overflow <= 1'b1;
        else if (overflow_clr)     r_overflow <= 1'b0;
    end

    assign overflow = r_overflow;
`endif

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
//==============================================================================
// Module      : tb_uart_tx_fifo
// Description : Directed self-checking bench for uart_tx_fifo (DATA_WIDTH=8,
//               DEPTH=16). It includes a behavioural transmitter model that
//               holds ready low for a programmable number of cycles per word.
// Revision    : 1.0 - initial release
//==============================================================================

module tb_uart_tx_fifo;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] wr_data;
    logic       wr_en;
    logic       full;
    logic       empty;
    logic [4:0] count;
    logic [7:0] tx_data;
    logic       tx_send;
    logic       tx_ready;
`ifdef UART_TX_FIFO_OVERFLOW_FLAG_EN
    logic       overflow;
    logic       overflow_clr;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    logic       ready_manual;
    logic       model_en;
    logic       model_ready = 1'b1;
    int         model_busy  = 0;
    int         busy_len;
    logic [7:0] cap_q [$];
    int         viol      = 0;
    int         max_count = 0;
    logic       prev_send = 1'b0;
    logic       saw_low   = 1'b0;
    logic       pulsed    = 1'b0;

    always #5 clk = ~clk;

    assign tx_ready = model_en ? model_ready : ready_manual;

    uart_tx_fifo #(
        .DATA_WIDTH (8),
        .DEPTH      (16)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wr_data      (wr_data),
        .wr_en        (wr_en),
        .full         (full),
        .empty        (empty),
        .count        (count),
        .tx_data      (tx_data),
        .tx_send      (tx_send),
        .tx_ready     (tx_ready)
`ifdef UART_TX_FIFO_OVERFLOW_FLAG_EN
        ,
        .overflow     (overflow),
        .overflow_clr (overflow_clr)
`endif
    );

    always @(posedge clk) begin
        if (int'(count) > max_count) max_count = int'(count);
        if (tx_send && prev_send) viol++;
        if (!tx_ready) saw_low = 1'b1;
        if (tx_send) begin
            if (pulsed && !saw_low) viol++;
            pulsed  = 1'b1;
            saw_low = 1'b0;
        end
        prev_send = tx_send;

        if (!model_en) begin
            model_ready <= 1'b1;
            model_busy  <= 0;
        end else if (model_ready && tx_send) begin
            cap_q.push_back(tx_data);
            model_ready <= 1'b0;
            model_busy  <= busy_len;
        end else if (!model_ready) begin
            if (model_busy <= 1) model_ready <= 1'b1;
            model_busy <= model_busy - 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n        = 1'b0;
        wr_en        = 1'b1;
        wr_data      = 8'h3C;
        ready_manual = 1'b1;
        model_en     = 1'b0;
        busy_len     = 100;
`ifdef UART_TX_FIFO_OVERFLOW_FLAG_EN
        overflow_clr = 1'b0;
`endif

        repeat (3) tick();
        check("reset_empty", empty, 1'b1);
        check("reset_full", full, 1'b0);
        check("reset_count", count, 5'd0);
        check("reset_send", tx_send, 1'b0);
        check("reset_data", tx_data, 8'h00);
        rst_n = 1'b1;
        wr_en = 1'b0;
        tick();
        check("post_reset_empty", empty, 1'b1);
        check("post_reset_count", count, 5'd0);

        wr_data = 8'hA5;
        wr_en   = 1'b1;
        tick();
        wr_en = 1'b0;
        check("lat_k1_count", count, 5'd1);
        check("lat_k1_send", tx_send, 1'b0);
        tick();
        check("lat_k2_send", tx_send, 1'b1);
        check("lat_k2_data", tx_data, 8'hA5);
        check("lat_k2_empty", empty, 1'b1);
        tick();
        check("lat_pulse_width", tx_send, 1'b0);
        check("lat_data_hold", tx_data, 8'hA5);
        ready_manual = 1'b0;
        tick();

        for (int i = 0; i < 16; i++) begin
            wr_data = 8'(i);
            wr_en   = 1'b1;
            tick();
        end
        wr_en = 1'b0;
        check("fill_full", full, 1'b1);
        check("fill_count", count, 5'd16);
        wr_data = 8'hFF;
        wr_en   = 1'b1;
        tick();
        wr_en = 1'b0;
        check("drop_count", count, 5'd16);
        check("drop_full", full, 1'b1);
`ifdef UART_TX_FIFO_OVERFLOW_FLAG_EN
        check("ovf_set", overflow, 1'b1);
        overflow_clr = 1'b1;
        wr_en        = 1'b1;
        tick();
        check("ovf_set_wins", overflow, 1'b1);
        wr_en = 1'b0;
        tick();
        check("ovf_clear", overflow, 1'b0);
        overflow_clr = 1'b0;
`endif

        cap_q.delete();
        model_en = 1'b1;
        for (int n = 0; n < 4000 && cap_q.size() < 16; n++) tick();
        check("drain_words", cap_q.size(), 16);
        for (int i = 0; i < 16; i++) begin
            check("drain_order", cap_q[i], 8'(i));
        end
        for (int n = 0; n < 400 && !model_ready; n++) tick();
        tick();
        check("drain_empty", empty, 1'b1);
        check("drain_protocol", viol, 0);

        cap_q.delete();
        busy_len  = 3;
        max_count = 0;
        for (int i = 0; i < 40; i++) begin
            wr_en = 1'b0;
            for (int n = 0; n < 200 && full; n++) tick();
            wr_data = 8'(i + 8'h40);
            wr_en   = 1'b1;
            tick();
        end
        wr_en = 1'b0;
        for (int n = 0; n < 2000 && cap_q.size() < 40; n++) tick();
        check("wrap_words", cap_q.size(), 40);
        for (int i = 0; i < 40; i++) begin
            check("wrap_order", cap_q[i], 8'(i + 8'h40));
        end
        check("wrap_max_count", (max_count <= 16), 1'b1);
        check("wrap_protocol", viol, 0);
        for (int n = 0; n < 50 && !model_ready; n++) tick();
        tick();

        model_en     = 1'b0;
        ready_manual = 1'b0;
        for (int i = 0; i < 16; i++) begin
            wr_data = 8'(i + 8'h80);
            wr_en   = 1'b1;
            tick();
        end
        check("both_pre_full", full, 1'b1);
        wr_data      = 8'hEE;
        ready_manual = 1'b1;
        tick();
        wr_en        = 1'b0;
        ready_manual = 1'b0;
        check("both_count", count, 5'd15);
        check("both_full", full, 1'b0);
        check("both_send", tx_send, 1'b1);
        check("both_data", tx_data, 8'h80);
`ifdef UART_TX_FIFO_OVERFLOW_FLAG_EN
        check("both_ovf", overflow, 1'b1);
`endif
        tick();
        tick();

        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            wr_data = 8'(i + 8'h10);
            wr_en   = 1'b1;
            tick();
        end
        wr_en        = 1'b0;
        ready_manual = 1'b1;
        tick();
        check("mid_pre_send", tx_send, 1'b1);
        check("mid_pre_count", count, 5'd5);
        rst_n = 1'b0;
        tick();
        check("mid_rst_send", tx_send, 1'b0);
        check("mid_rst_count", count, 5'd0);
        check("mid_rst_empty", empty, 1'b1);
        check("mid_rst_data", tx_data, 8'h00);
`ifdef UART_TX_FIFO_OVERFLOW_FLAG_EN
        check("mid_rst_ovf", overflow, 1'b0);
`endif
        rst_n = 1'b1;
        repeat (3) tick();
        check("mid_lost_send", tx_send, 1'b0);
        check("mid_lost_empty", empty, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
